// File: rtl/wasca_pkg.sv
// Shared definitions for the SPI sync strobe conditioner.
// Contents:
//   - ST_*_ENC   : fixed binary encodings of the supervision FSM states
//   - state_e    : FSM state type built on those encodings
package wasca_pkg;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_ACTIVE_ENC  = 2'd1;
    localparam logic [1:0] ST_TIMEOUT_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_ACTIVE  = ST_ACTIVE_ENC,
        ST_TIMEOUT = ST_TIMEOUT_ENC
    } state_e;

endpackage

// File: rtl/wasca_sync_filter.sv
// Synchroniser chain plus glitch filter for one asynchronous input.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   raw_i    in   asynchronous input
//   level_o  out  filtered level (registered)
//   edge_o   out  strobe: level_o toggles on the next clk edge
module wasca_sync_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic edge_o
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced_s;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [CW-1:0]          cnt_inc_s;
    logic                   level_q;
    logic                   level_d;
    logic                   edge_s;

    assign synced_s  = sync_q[SYNC_STAGES-1];
    assign cnt_inc_s = cnt_q + CW'(1);

    // Plain shift chain: no logic between stages so metastability can settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Filter decision: count consecutive disagreeing cycles, accept on the Nth.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        edge_s  = 1'b0;
        if (synced_s != level_q) begin
            if (cnt_inc_s == CW'(FILTER_CYCLES)) begin
                level_d = ~level_q;
                edge_s  = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_inc_s;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Filter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
    // Combinational look-ahead so the parent can register its pulses in the
    // same edge that level_o changes.
    assign edge_o  = edge_s;

endmodule

// File: rtl/wasca_spi_sync_cond.sv
// Conditions the raw asynchronous SPI sync strobe from the cartridge connector.
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   spi_sync_raw  in   asynchronous strobe from pin
//   clear_count   in   one-cycle request to zero edge_count
//   filt_level    out  filtered level, feeds the SPI-sync PIO in_port
//   rise_pulse    out  one-cycle pulse on accepted rise
//   fall_pulse    out  one-cycle pulse on accepted fall
//   active        out  FSM in ACTIVE or TIMEOUT
//   timeout       out  sticky stuck-high flag, cleared by fall or reset
//   edge_count    out  wrapping count of accepted rises
module wasca_spi_sync_cond
    import wasca_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_sync_raw,
    input  logic             clear_count,
    output logic             filt_level,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             active,
    output logic             timeout,
    output logic [CNT_W-1:0] edge_count
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             level_s;
    logic             edge_s;
    logic             rise_s;
    logic             fall_s;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] tmo_q;
    logic [CNT_W-1:0] tmo_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rise_q;
    logic             fall_q;
    logic             active_q;
    logic             timeout_q;

    wasca_sync_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (spi_sync_raw),
        .level_o (level_s),
        .edge_o  (edge_s)
    );

    // The level is about to toggle, so its current value tells the direction.
    assign rise_s = edge_s & ~level_s;
    assign fall_s = edge_s &  level_s;

    // Supervision FSM next state; a fall always takes priority over expiry.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d = ST_ACTIVE;
                    tmo_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (fall_s) begin
                    state_d = ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            ST_TIMEOUT: begin
                if (fall_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end
        endcase
    end

    // Edge counter next value; a rise coincident with a clear still counts.
    always_comb begin
        cnt_d = cnt_q;
        if (rise_s) begin
            if (clear_count) begin
                cnt_d = CNT_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (clear_count) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers; flags are derived from the next state so
    // they line up with the pulse cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tmo_q     <= '0;
            cnt_q     <= '0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            active_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            rise_q    <= rise_s;
            fall_q    <= fall_s;
            active_q  <= (state_d != ST_IDLE);
            timeout_q <= (state_d == ST_TIMEOUT);
        end
    end

    assign filt_level = level_s;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign active     = active_q;
    assign timeout    = timeout_q;
    assign edge_count = cnt_q;

endmodule
